// File: rtl/duty_calc_pkg.sv
// Shared types and width helpers for the duty-cycle calculator.
// The BCD state only exists when DUTY_CALC_BCD_EN is defined.
package duty_calc_pkg;

    localparam int SCALE_PM    = 1000;
    // Headroom needed for high*1000 (1000 < 2**10).
    localparam int MUL_EXTRA_W = 10;

`ifdef DUTY_CALC_BCD_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_BCD  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;
`endif

    function automatic int num_width(input int cnt_w);
        return cnt_w + MUL_EXTRA_W;
    endfunction

    function automatic int rem_width(input int cnt_w);
        return cnt_w + 2;
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [15:0] bcd_add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/duty_cycle_calc_bin2bcd_seq.sv
// Sequential double-dabble: BIN_W shift cycles after a start pulse.
// done_o flags the cycle whose closing edge produces the final digits on bcd_o.
module bin2bcd_seq
    import duty_calc_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [15:0]      bcd_o
);

    localparam int CW = $clog2(BIN_W + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [14:0]      adj;

    always_comb begin
        adj   = 15'(bcd_add3(bcd_q));
        cnt_d = cnt_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        if (start_i) begin
            cnt_d = CW'(BIN_W);
            bin_d = bin_i;
            bcd_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            bin_d = bin_q << 1;
            bcd_d = {adj, bin_q[BIN_W-1]};
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign bcd_o  = {adj, bin_q[BIN_W-1]};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_ff @(posedge sys_clk) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
    end

endmodule

// File: rtl/duty_cycle_calc.sv
// Per-mille duty cycle high*1000/(high+low) via shift-add multiply and restoring divide.
// Define DUTY_CALC_BCD_EN to add the duty_bcd output and a sequential BCD conversion stage.
module duty_cycle_calc
    import duty_calc_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SCALE = SCALE_PM,
    parameter int RES_W = 10
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] high_cnt,
    input  logic [CNT_W-1:0] low_cnt,
    input  logic             start,
    output logic             busy,
    output logic [RES_W-1:0] duty,
    output logic             duty_valid,
    output logic             err_zero,
    output logic             overrun
`ifdef DUTY_CALC_BCD_EN
    ,
    output logic [15:0]      duty_bcd
`endif
);

    localparam int NUM_W = num_width(CNT_W);
    localparam int REM_W = rem_width(CNT_W);
    localparam int DEN_W = CNT_W + 1;
    localparam int SH_W  = REM_W + 1;
    localparam int BIT_W = $clog2(NUM_W);

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] high_q, high_d, low_q, low_d;
    logic [NUM_W-1:0] num_q, num_d, num_x, quo;
    logic [DEN_W-1:0] den_q, den_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [SH_W-1:0]  rem_sh, diff;
    logic             q_bit;
    logic [RES_W-1:0] res_sat, duty_q, duty_d;
    logic             valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
`ifdef DUTY_CALC_BCD_EN
    logic [RES_W-1:0] res_q, res_d;
    logic [15:0]      bcd_q, bcd_d, bcd_val;
    logic             bcd_go, bcd_done;
`endif

    // One restoring-division step; the quotient bit shifts into the numerator register.
    always_comb begin
        num_x   = NUM_W'(high_q);
        rem_sh  = {rem_q, num_q[NUM_W-1]};
        diff    = rem_sh - SH_W'(den_q);
        q_bit   = ~diff[REM_W];
        quo     = {num_q[NUM_W-2:0], q_bit};
        res_sat = (quo > NUM_W'(SCALE)) ? RES_W'(SCALE) : quo[RES_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        high_d  = high_q;
        low_d   = low_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        duty_d  = duty_q;
        valid_d = 1'b0;
        err_d   = err_q;
        ovr_d   = ovr_q;
`ifdef DUTY_CALC_BCD_EN
        res_d   = res_q;
        bcd_d   = bcd_q;
        bcd_go  = 1'b0;
`endif
        if (start && state_q != ST_IDLE) ovr_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    high_d  = high_cnt;
                    low_d   = low_cnt;
                    ovr_d   = 1'b0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                num_d   = (num_x << 10) - (num_x << 4) - (num_x << 3);
                den_d   = DEN_W'(high_q) + DEN_W'(low_q);
                rem_d   = '0;
                bit_d   = BIT_W'(NUM_W - 1);
                state_d = ST_DIV;
            end
            ST_DIV: begin
                // A zero denominator is resolved on the first DIV cycle, before any bit is consumed.
                if (den_q == '0) begin
                    duty_d  = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
`ifdef DUTY_CALC_BCD_EN
                    bcd_d   = '0;
`endif
                    state_d = ST_IDLE;
                end else begin
                    num_d = quo;
                    rem_d = q_bit ? diff[REM_W-1:0] : rem_sh[REM_W-1:0];
                    bit_d = bit_q - 1'b1;
                    if (bit_q == '0) begin
`ifdef DUTY_CALC_BCD_EN
                        res_d   = res_sat;
                        bcd_go  = 1'b1;
                        state_d = ST_BCD;
`else
                        duty_d  = res_sat;
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef DUTY_CALC_BCD_EN
            ST_BCD: begin
                if (bcd_done) begin
                    duty_d  = res_q;
                    bcd_d   = bcd_val;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef DUTY_CALC_BCD_EN
            bcd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            duty_q  <= duty_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
`ifdef DUTY_CALC_BCD_EN
            bcd_q   <= bcd_d;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        high_q <= high_d;
        low_q  <= low_d;
        num_q  <= num_d;
        den_q  <= den_d;
        rem_q  <= rem_d;
`ifdef DUTY_CALC_BCD_EN
        res_q  <= res_d;
`endif
    end

`ifdef DUTY_CALC_BCD_EN
    bin2bcd_seq #(.BIN_W(RES_W)) u_bcd (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .start_i (bcd_go),
        .bin_i   (res_sat),
        .done_o  (bcd_done),
        .bcd_o   (bcd_val)
    );
    assign duty_bcd = bcd_q;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign duty       = duty_q;
    assign duty_valid = valid_q;
    assign err_zero   = err_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_duty_cycle_calc.sv
// Self-checking bench for duty_cycle_calc: vector table plus scoreboard of expected results,
// with hand-written overrun, back-to-back and mid-calculation reset sequences.
module tb_duty_cycle_calc;

    localparam int CNT_W = 32;
    localparam int RES_W = 10;
`ifdef DUTY_CALC_BCD_EN
    localparam int LAT_NORM = 53;
`else
    localparam int LAT_NORM = 43;
`endif
    localparam int LAT_ZERO = 2;
    localparam int NVEC     = 11;

    typedef struct {
        logic [31:0] high;
        logic [31:0] low;
        logic [9:0]  duty;
        logic        err;
    } vec_t;

    typedef struct {
        logic [9:0]  duty;
        logic        err;
        int          cyc;
        logic [15:0] bcd;
    } exp_t;

    logic             sys_clk;
    logic             rst_n;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             start;
    logic             busy;
    logic [RES_W-1:0] duty;
    logic             duty_valid;
    logic             err_zero;
    logic             overrun;
`ifdef DUTY_CALC_BCD_EN
    logic [15:0]      duty_bcd;
`endif

    exp_t sb[$];
    vec_t vt[NVEC];
    int   errs      = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   valid_cnt = 0;

    duty_cycle_calc #(.CNT_W(CNT_W), .RES_W(RES_W)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .start      (start),
        .busy       (busy),
        .duty       (duty),
        .duty_valid (duty_valid),
        .err_zero   (err_zero),
        .overrun    (overrun)
`ifdef DUTY_CALC_BCD_EN
        ,
        .duty_bcd   (duty_bcd)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Scoreboard consumer: every duty_valid pulse must match the oldest pending result.
    always @(negedge sys_clk) begin
        exp_t e;
        if (rst_n && duty_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL stray_valid: duty_valid=1 (duty=%0d), required no pulse", duty);
            end else begin
                e = sb.pop_front();
                chk("duty", 64'(duty), 64'(e.duty));
                chk("err_zero", 64'(err_zero), 64'(e.err));
                chk("valid_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_at_valid", 64'(busy), 64'd0);
`ifdef DUTY_CALC_BCD_EN
                chk("duty_bcd", 64'(duty_bcd), 64'(e.bcd));
`endif
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic do_start(input logic [31:0] h, input logic [31:0] l,
                            input logic [9:0] d, input logic e);
        exp_t x;
        high_cnt = h;
        low_cnt  = l;
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        high_cnt = $urandom;
        low_cnt  = $urandom;
        x.duty = d;
        x.err  = e;
        x.cyc  = cyc + (e ? LAT_ZERO : LAT_NORM);
        x.bcd  = to_bcd(int'(d));
        sb.push_back(x);
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL wait_done: %0d results still pending after %0d cycles, required 0", sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!duty_valid && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (!duty_valid) begin
            checks++;
            errs++;
            $display("FAIL wait_valid: duty_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int vc0;

        vt[0]  = '{32'd25_000_000,  32'd75_000_000, 10'd250,  1'b0};
        vt[1]  = '{32'd1,           32'd2,          10'd333,  1'b0};
        vt[2]  = '{32'd100_000_000, 32'd0,          10'd1000, 1'b0};
        vt[3]  = '{32'd0,           32'd0,          10'd0,    1'b1};
        vt[4]  = '{32'd3,           32'd1,          10'd750,  1'b0};
        vt[5]  = '{32'd0,           32'd5,          10'd0,    1'b0};
        vt[6]  = '{32'd2,           32'd3,          10'd400,  1'b0};
        vt[7]  = '{32'hFFFF_FFFF,   32'hFFFF_FFFF,  10'd500,  1'b0};
        vt[8]  = '{32'hFFFF_FFFF,   32'd1,          10'd999,  1'b0};
        vt[9]  = '{32'd1,           32'd999_999,    10'd0,    1'b0};
        vt[10] = '{32'd7,           32'd0,          10'd1000, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        high_cnt = '0;
        low_cnt  = '0;
        repeat (3) @(negedge sys_clk);
        chk("reset_duty", 64'(duty), 64'd0);
        chk("reset_valid", 64'(duty_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err_zero", 64'(err_zero), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
`ifdef DUTY_CALC_BCD_EN
        chk("reset_duty_bcd", 64'(duty_bcd), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge sys_clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge sys_clk);
            do_start(vt[i].high, vt[i].low, vt[i].duty, vt[i].err);
            wait_done();
        end

        // Start dropped while busy: overrun sets, result of the running calculation unchanged.
        @(negedge sys_clk);
        do_start(32'd25_000_000, 32'd75_000_000, 10'd250, 1'b0);
        repeat (9) @(negedge sys_clk);
        chk("overrun_before_drop", 64'(overrun), 64'd0);
        high_cnt = 32'd1;
        low_cnt  = 32'd2;
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("busy_during_drop", 64'(busy), 64'd1);
        wait_valid();
        chk("overrun_sticky", 64'(overrun), 64'd1);

        // Back-to-back start on the duty_valid cycle is accepted and clears overrun.
        do_start(32'd3, 32'd1, 10'd750, 1'b0);
        chk("overrun_cleared", 64'(overrun), 64'd0);
        wait_done();

        // Asynchronous reset in the middle of a division.
        @(negedge sys_clk);
        do_start(32'd1, 32'd2, 10'd333, 1'b0);
        repeat (5) @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("overrun_before_reset", 64'(overrun), 64'd1);
        repeat (14) @(negedge sys_clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_duty", 64'(duty), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_overrun", 64'(overrun), 64'd0);
        chk("async_rst_valid", 64'(duty_valid), 64'd0);
        chk("async_rst_err_zero", 64'(err_zero), 64'd0);
        sb.delete();
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        vc0 = valid_cnt;
        repeat (60) @(negedge sys_clk);
        chk("no_valid_after_reset", 64'(valid_cnt - vc0), 64'd0);
        chk("idle_after_reset", 64'(busy), 64'd0);

        // Recovery after reset.
        do_start(32'd2, 32'd3, 10'd400, 1'b0);
        wait_done();

        repeat (3) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
